mem_req_splitter: RTL and testbench

- Sits directly downstream of the memory-config stage.
- Consumes its per-stream buffer descriptors (vaddr, size) over ready/valid.
- Splits each buffer into memory requests that never exceed MAX_REQ_BYTES and never cross a MAX_REQ_BYTES-aligned boundary.
- Limits in-flight requests, matches in-order completions back to buffers, and pulses buf_done once per fully completed buffer.

---
 rtl/libstf.sv | 16 +
 rtl/mem_req_order_fifo.sv | 50 +++++
 rtl/mem_req_splitter.sv | 126 ++++++++++++
 tb/tb_mem_req_splitter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/libstf.sv
// Shared types and default sizing for the memory-request path.
package libstf;

  localparam int VADDRESS_BITS       = 48;
  localparam int ALLOC_SIZE_BITS     = 32;
  localparam int MEM_REQ_MAX_BYTES   = 4096;
  localparam int MEM_MAX_OUTSTANDING = 16;

  typedef logic [VADDRESS_BITS-1:0]              vaddress_t;
  typedef logic [ALLOC_SIZE_BITS-1:0]            alloc_size_t;
  typedef logic [$clog2(MEM_REQ_MAX_BYTES):0]    req_len_t;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SPLIT = 1'b1;

endpackage

// File: rtl/mem_req_order_fifo.sv
// 1-bit FIFO recording, per issued request, whether it closes its buffer.
module mem_req_order_fifo #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_empty,
  output logic o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is legal only when a pop frees the slot.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/mem_req_splitter.sv
// Splits buffer descriptors into boundary-respecting memory requests and
// reports buffer completion from in-order request completions.
module mem_req_splitter
  import libstf::*;
#(
  parameter int VADDR_BITS      = VADDRESS_BITS,
  parameter int SIZE_BITS       = ALLOC_SIZE_BITS,
  parameter int MAX_REQ_BYTES   = MEM_REQ_MAX_BYTES,
  parameter int MAX_OUTSTANDING = MEM_MAX_OUTSTANDING
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 buf_valid,
  output logic                                 buf_ready,
  input  logic [VADDR_BITS-1:0]                buf_vaddr,
  input  logic [SIZE_BITS-1:0]                 buf_size,
  output logic                                 req_valid,
  input  logic                                 req_ready,
  output logic [VADDR_BITS-1:0]                req_vaddr,
  output logic [$clog2(MAX_REQ_BYTES):0]       req_len,
  output logic                                 req_last,
  input  logic                                 cpl_valid,
  output logic                                 buf_done,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 err_cpl
);

  localparam int LW   = $clog2(MAX_REQ_BYTES) + 1;
  localparam int OFFW = LW - 1;
  localparam int OW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [LW-1:0] MAX_REQ_L = LW'(MAX_REQ_BYTES);
  localparam logic [OW-1:0] MAX_OUT_L = OW'(MAX_OUTSTANDING);

  logic                  r_state;
  logic [VADDR_BITS-1:0] r_cur_addr;
  logic [SIZE_BITS-1:0]  r_remaining;
  logic [OW-1:0]         r_outstanding;
  logic                  r_err;
  logic                  r_buf_done;

  logic [OFFW-1:0]       w_off;
  logic [LW-1:0]         w_space;
  logic [LW-1:0]         w_len;
  logic                  w_last;
  logic                  w_split;
  logic                  w_issue;
  logic                  w_cpl_ok;
  logic                  w_fifo_dout;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_fifo_flags_unused;

  // Bytes left before the next MAX_REQ_BYTES boundary bound the request.
  assign w_off   = r_cur_addr[OFFW-1:0];
  assign w_space = MAX_REQ_L - {1'b0, w_off};
  assign w_len   = (r_remaining < SIZE_BITS'(w_space)) ? LW'(r_remaining) : w_space;
  assign w_last  = (SIZE_BITS'(w_len) == r_remaining);

  assign w_split   = (r_state == ST_SPLIT);
  assign buf_ready = !w_split;
  assign req_valid = w_split && (r_outstanding < MAX_OUT_L);
  assign req_vaddr = w_split ? r_cur_addr : '0;
  assign req_len   = w_split ? w_len : '0;
  assign req_last  = w_split && w_last;

  assign w_issue  = req_valid && req_ready;
  assign w_cpl_ok = cpl_valid && (r_outstanding != '0);

  assign outstanding = r_outstanding;
  assign err_cpl     = r_err;
  assign buf_done    = r_buf_done;

  // The FIFO occupancy always mirrors r_outstanding, so its flags are redundant.
  assign w_fifo_flags_unused = w_fifo_empty | w_fifo_full;

  mem_req_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_issue),
    .i_din   (w_last),
    .i_pop   (w_cpl_ok),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_buf_done    <= 1'b0;
    end else begin
      r_buf_done <= w_cpl_ok && w_fifo_dout;
      if (cpl_valid && !w_cpl_ok) r_err <= 1'b1;

      case ({w_issue, w_cpl_ok})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (buf_valid) begin
            r_cur_addr  <= buf_vaddr;
            r_remaining <= buf_size;
            r_state     <= ST_SPLIT;
          end
        end
        default: begin
          if (w_issue) begin
            r_cur_addr  <= r_cur_addr + VADDR_BITS'(w_len);
            r_remaining <= r_remaining - SIZE_BITS'(w_len);
            if (w_last) r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_splitter.sv
// Directed and randomized checks of mem_req_splitter against a queue-based model.
module tb_mem_req_splitter;

  localparam int VB  = 48;
  localparam int SB  = 32;
  localparam int MRB = 4096;
  localparam int MO  = 2;
  localparam int LW  = $clog2(MRB) + 1;
  localparam int OW  = $clog2(MO) + 1;
  localparam longint unsigned ADDR_MASK = (64'd1 << VB) - 64'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          buf_valid = 1'b0;
  logic          buf_ready;
  logic [VB-1:0] buf_vaddr = '0;
  logic [SB-1:0] buf_size = '0;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [VB-1:0] req_vaddr;
  logic [LW-1:0] req_len;
  logic          req_last;
  logic          cpl_valid = 1'b0;
  logic          buf_done;
  logic [OW-1:0] outstanding;
  logic          err_cpl;

  mem_req_splitter #(
    .VADDR_BITS      (VB),
    .SIZE_BITS       (SB),
    .MAX_REQ_BYTES   (MRB),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_valid   (buf_valid),
    .buf_ready   (buf_ready),
    .buf_vaddr   (buf_vaddr),
    .buf_size    (buf_size),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_vaddr   (req_vaddr),
    .req_len     (req_len),
    .req_last    (req_last),
    .cpl_valid   (cpl_valid),
    .buf_done    (buf_done),
    .outstanding (outstanding),
    .err_cpl     (err_cpl)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned addr;
    longint unsigned len;
    bit              last;
  } req_t;

  req_t exp_q[$];
  req_t log_q[$];
  bit   order_q[$];
  int   m_out;
  bit   m_busy;
  bit   m_err;
  bit   m_done;
  int   n_dut_done;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected request list for one buffer, straight from the splitting rules.
  task automatic gen_requests(input longint unsigned addr, input longint unsigned size);
    longint unsigned a = addr;
    longint unsigned rem = size;
    longint unsigned chunk;
    req_t r;
    do begin
      chunk = MRB - (a % MRB);
      if (rem < chunk) chunk = rem;
      r.addr = a;
      r.len  = chunk;
      r.last = (rem == chunk);
      exp_q.push_back(r);
      a   = (a + chunk) & ADDR_MASK;
      rem = rem - chunk;
    end while (rem != 0);
  endtask

  // Compare all outputs with the model, then advance one clock and update the model.
  task automatic cycle();
    bit   exp_valid;
    bit   hs;
    bit   cpl_ok;
    bit   accept;
    req_t r;
    exp_valid = m_busy && (m_out < MO);
    check("buf_ready", buf_ready, !m_busy);
    check("req_valid", req_valid, exp_valid);
    check("outstanding", outstanding, m_out);
    check("err_cpl", err_cpl, m_err);
    check("buf_done", buf_done, m_done);
    if (exp_valid && exp_q.size() > 0) begin
      check("req_vaddr", req_vaddr, exp_q[0].addr);
      check("req_len", req_len, exp_q[0].len);
      check("req_last", req_last, exp_q[0].last);
    end
    hs     = exp_valid && req_ready;
    cpl_ok = cpl_valid && (m_out > 0);
    accept = buf_valid && !m_busy;
    if (hs) begin
      r.addr = req_vaddr;
      r.len  = req_len;
      r.last = req_last;
      log_q.push_back(r);
    end
    n_dut_done += int'(buf_done);

    @(posedge clk);
    #1;

    m_done = 1'b0;
    if (cpl_ok) m_done = order_q.pop_front();
    else if (cpl_valid) m_err = 1'b1;
    if (hs && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      order_q.push_back(r.last);
      if (r.last) m_busy = 1'b0;
    end
    if (accept) begin
      gen_requests(longint'(buf_vaddr), longint'(buf_size));
      m_busy = 1'b1;
    end
    m_out = m_out + int'(hs) - int'(cpl_ok);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    buf_valid = 1'b0;
    cpl_valid = 1'b0;
    req_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    order_q.delete();
    m_out  = 0;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_done = 1'b0;
    check("rst_buf_ready", buf_ready, 1'b1);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err_cpl", err_cpl, 1'b0);
    check("rst_buf_done", buf_done, 1'b0);
    rst = 1'b0;
  endtask

  task automatic set_buf(input longint unsigned addr, input longint unsigned size);
    buf_valid = 1'b1;
    buf_vaddr = VB'(addr);
    buf_size  = SB'(size);
  endtask

  int done_before;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    n_dut_done = 0;
    @(posedge clk);
    do_reset();

    // Unaligned buffer crossing one boundary.
    log_q.delete();
    req_ready = 1'b1;
    set_buf(64'h1F00, 64'h300);
    cycle();
    buf_valid = 1'b0;
    repeat (3) cycle();
    check("t1_nreq", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t1_addr0", log_q[0].addr, 64'h1F00);
      check("t1_len0", log_q[0].len, 64'h100);
      check("t1_last0", log_q[0].last, 1'b0);
      check("t1_addr1", log_q[1].addr, 64'h2000);
      check("t1_len1", log_q[1].len, 64'h200);
      check("t1_last1", log_q[1].last, 1'b1);
    end
    done_before = n_dut_done;
    cpl_valid = 1'b1;
    cycle();
    cycle();
    cpl_valid = 1'b0;
    check("t1_done_early", buf_done, 1'b1);
    cycle();
    cycle();
    check("t1_done_count", n_dut_done - done_before, 1);

    // Aligned buffer split into three requests issued on consecutive cycles.
    log_q.delete();
    set_buf(64'h1000, 64'h2800);
    cycle();
    buf_valid = 1'b0;
    cycle();
    cpl_valid = 1'b1;
    cycle();
    cycle();
    cycle();
    cpl_valid = 1'b0;
    cycle();
    cycle();
    check("t2_nreq", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t2_addr2", log_q[2].addr, 64'h3000);
      check("t2_len1", log_q[1].len, 64'h1000);
      check("t2_len2", log_q[2].len, 64'h800);
      check("t2_last1", log_q[1].last, 1'b0);
      check("t2_last2", log_q[2].last, 1'b1);
    end

    // Backpressure and the outstanding limit.
    req_ready = 1'b0;
    set_buf(64'h0, 64'h3000);
    cycle();
    buf_valid = 1'b0;
    repeat (3) cycle();
    req_ready = 1'b1;
    repeat (4) cycle();
    check("t3_stall_valid", req_valid, 1'b0);
    check("t3_stall_out", outstanding, MO);
    cpl_valid = 1'b1;
    cycle();
    cpl_valid = 1'b0;
    check("t3_resume_valid", req_valid, 1'b1);
    cycle();
    cpl_valid = 1'b1;
    repeat (2) cycle();
    cpl_valid = 1'b0;
    repeat (2) cycle();

    // Zero-size buffer, then a completion coinciding with a request handshake.
    set_buf(64'h40, 64'h0);
    cycle();
    buf_valid = 1'b0;
    check("t4_zero_len", req_len, 0);
    check("t4_zero_last", req_last, 1'b1);
    cycle();
    set_buf(64'h80, 64'h100);
    cycle();
    buf_valid = 1'b0;
    cpl_valid = 1'b1;
    cycle();
    check("t4_same_cycle_out", outstanding, 1);
    check("t4_done_first", buf_done, 1'b1);
    cycle();
    cpl_valid = 1'b0;
    check("t4_done_second", buf_done, 1'b1);
    cycle();

    // Completion with nothing outstanding, then reset in the middle of a buffer.
    cpl_valid = 1'b1;
    cycle();
    cpl_valid = 1'b0;
    check("t5_err_set", err_cpl, 1'b1);
    check("t5_err_out", outstanding, 0);
    repeat (2) cycle();
    req_ready = 1'b0;
    set_buf(64'h0, 64'h3000);
    cycle();
    buf_valid = 1'b0;
    cycle();
    req_ready = 1'b1;
    cycle();
    do_reset();
    repeat (2) cycle();

    // Randomized traffic, including address wrap and boundary-adjacent starts.
    for (int i = 0; i < 3000; i++) begin
      longint unsigned a;
      longint unsigned s;
      case ($urandom_range(0, 3))
        0:       a = {$urandom, $urandom} & ADDR_MASK;
        1:       a = ADDR_MASK - longint'($urandom_range(0, 8191));
        2:       a = (longint'($urandom_range(0, 255)) * MRB) - longint'($urandom_range(0, 64));
        default: a = longint'($urandom_range(0, 65535));
      endcase
      a = a & ADDR_MASK;
      s = ($urandom_range(0, 7) == 0) ? 64'd0 : longint'($urandom_range(1, 16'h3000));
      buf_valid = ($urandom_range(0, 1) == 1);
      buf_vaddr = VB'(a);
      buf_size  = SB'(s);
      req_ready = ($urandom_range(0, 3) != 0);
      if (m_out > 0) cpl_valid = ($urandom_range(0, 1) == 1);
      else cpl_valid = ($urandom_range(0, 99) == 0);
      cycle();
    end
    buf_valid = 1'b0;
    cpl_valid = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
